// File: rtl/mem_copy_engine.sv
// Block copy engine: sole master of a single-port byte memory while busy,
// alternating one read and one write cycle per byte, with a running checksum.
module mem_copy_engine #(
  parameter int ADDR_LEN = 8,
  parameter int WORD_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_LEN-1:0] src,
  input  logic [ADDR_LEN-1:0] dst,
  input  logic [ADDR_LEN:0]   len,
  output logic                busy,
  output logic                done,
  output logic [WORD_LEN-1:0] checksum,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_r_en,
  output logic                mem_w_en,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_LEN-1:0] r_src_ptr;
  logic [ADDR_LEN-1:0] r_dst_ptr;
  logic [ADDR_LEN:0]   r_count;
  logic [WORD_LEN-1:0] r_data;
  logic [WORD_LEN-1:0] r_checksum;
  logic                w_last;

  assign w_last = (r_count == {{ADDR_LEN{1'b0}}, 1'b1});

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = (len != '0) ? S_READ : S_DONE;
      S_READ:  w_state_next = S_WRITE;
      S_WRITE: w_state_next = w_last ? S_DONE : S_READ;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath; a zero-length request only clears the checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_ptr  <= '0;
      r_dst_ptr  <= '0;
      r_count    <= '0;
      r_data     <= '0;
      r_checksum <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_checksum <= '0;
            if (len != '0) begin
              r_src_ptr <= src;
              r_dst_ptr <= dst;
              r_count   <= len;
            end
          end
        end
        S_READ: r_data <= mem_rdata;
        S_WRITE: begin
          r_src_ptr  <= r_src_ptr + 1'b1;
          r_dst_ptr  <= r_dst_ptr + 1'b1;
          r_count    <= r_count - 1'b1;
          r_checksum <= r_checksum + r_data;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only; idle bus is driven to zero.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    mem_wdata = '0;
    checksum  = r_checksum;
    case (r_state)
      S_READ: begin
        busy     = 1'b1;
        mem_r_en = 1'b1;
        mem_addr = r_src_ptr;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_w_en  = 1'b1;
        mem_addr  = r_dst_ptr;
        mem_wdata = r_data;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Testbench for mem_copy_engine: behavioural byte memory, vector table of
// copies plus hand-written sequences for busy-start, reset and back-to-back.
module tb_mem_copy_engine;

  typedef struct packed {
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [8:0]  len;
    logic [2:0]  ndata;
    logic [31:0] data;
    logic [7:0]  exp_chk;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] src = '0;
  logic [7:0] dst = '0;
  logic [8:0] len = '0;
  logic       busy, done, mem_r_en, mem_w_en;
  logic [7:0] checksum, mem_addr, mem_wdata, mem_rdata;

  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [7:0] mem [256];

  int total = 0;
  int bad = 0;
  int viol_both = 0;
  int viol_addr = 0;
  int viol_done = 0;
  logic       mon_done_prev = 1'b0;
  logic       mon_en = 1'b0;
  logic [7:0] mon_addr = '0;

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_LEN(8), .WORD_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .checksum(checksum),
    .mem_addr(mem_addr), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory: asynchronous read, write at the clock edge; bench preload port wins.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (ld_en)         mem[ld_addr] <= ld_data;
    else if (mem_w_en) mem[mem_addr] <= mem_wdata;
  end

  // Protocol monitor
  always @(negedge clk) begin
    if (mem_r_en && mem_w_en) viol_both <= viol_both + 1;
    if (done && mon_done_prev) viol_done <= viol_done + 1;
    mon_done_prev <= done;
    mon_en        <= mem_r_en | mem_w_en;
    mon_addr      <= mem_addr;
  end
  always @(posedge clk) begin
    if (mon_en && (mem_addr != mon_addr)) viol_addr <= viol_addr + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] bg(input int i);
    return 8'(i * 13 + 7);
  endfunction

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic load_bg();
    for (int i = 0; i < 256; i++) load(8'(i), bg(i));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n, done_cyc, busy_cnt, rcnt, wcnt, addr_bad, mem_bad;
    logic [7:0] model [256];
    logic [7:0] mchk, b;
    n = int'(v.len);
    load_bg();
    for (int k = 0; k < int'(v.ndata); k++) load(8'(v.src + k), v.data[8*k +: 8]);
    for (int i = 0; i < 256; i++) model[i] = mem[i];
    mchk = '0;
    for (int k = 0; k < n; k++) begin
      b = model[8'(v.src + k)];
      model[8'(v.dst + k)] = b;
      mchk = mchk + b;
    end
    src = v.src; dst = v.dst; len = v.len; start = 1'b1;
    tick();
    start = 1'b0;
    done_cyc = -1; busy_cnt = 0; rcnt = 0; wcnt = 0; addr_bad = 0; mem_bad = 0;
    for (int c = 1; c <= 2 * n + 4; c++) begin
      if (busy) busy_cnt++;
      if (mem_r_en) begin
        if (mem_addr != 8'(v.src + rcnt)) addr_bad++;
        rcnt++;
      end
      if (mem_w_en) begin
        if (mem_addr != 8'(v.dst + wcnt)) addr_bad++;
        wcnt++;
      end
      if (done && done_cyc < 0) done_cyc = c;
      tick();
    end
    for (int i = 0; i < 256; i++) if (mem[i] != model[i]) mem_bad++;
    chk($sformatf("v%0d done_cycle", idx), done_cyc, 2 * n + 1);
    chk($sformatf("v%0d busy_cycles", idx), busy_cnt, 2 * n);
    chk($sformatf("v%0d reads", idx), rcnt, n);
    chk($sformatf("v%0d writes", idx), wcnt, n);
    chk($sformatf("v%0d bus_addr_errs", idx), addr_bad, 0);
    chk($sformatf("v%0d checksum", idx), int'(checksum), int'(v.exp_chk));
    chk($sformatf("v%0d checksum_model", idx), int'(checksum), int'(mchk));
    chk($sformatf("v%0d mem_errs", idx), mem_bad, 0);
    $display("txn v%0d src=%02h dst=%02h len=%0d done_cyc=%0d checksum=%02h",
             idx, v.src, v.dst, n, done_cyc, checksum);
  endtask

  initial begin
    vec_t vecs [6];
    int   done_cyc, done_cnt, busy_cnt;

    vecs[0] = '{src: 8'h10, dst: 8'h80, len: 9'd4,   ndata: 3'd4, data: 32'h44332211, exp_chk: 8'hAA};
    vecs[1] = '{src: 8'h20, dst: 8'h90, len: 9'd0,   ndata: 3'd0, data: 32'h0,        exp_chk: 8'h00};
    vecs[2] = '{src: 8'hFE, dst: 8'h40, len: 9'd4,   ndata: 3'd4, data: 32'h0201F1F0, exp_chk: 8'hE4};
    vecs[3] = '{src: 8'h05, dst: 8'h06, len: 9'd1,   ndata: 3'd1, data: 32'h7F,       exp_chk: 8'h7F};
    vecs[4] = '{src: 8'h10, dst: 8'h11, len: 9'd3,   ndata: 3'd3, data: 32'h00C0B0A0, exp_chk: 8'hE0};
    vecs[5] = '{src: 8'h20, dst: 8'h20, len: 9'd256, ndata: 3'd0, data: 32'h0,        exp_chk: 8'h80};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_checksum", int'(checksum), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_enables", int'({mem_r_en, mem_w_en}), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // A start issued during a transfer is ignored, not queued
    load_bg();
    load(8'h30, 8'h5A);
    load(8'h31, 8'hA5);
    src = 8'h30; dst = 8'h90; len = 9'd2; start = 1'b1;
    tick();
    start = 1'b0;
    done_cyc = -1; done_cnt = 0; busy_cnt = 0;
    for (int c = 1; c <= 14; c++) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy) busy_cnt++;
      if (c == 3) begin
        src = 8'h00; dst = 8'hE0; len = 9'd8; start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("busy_start done_cycle", done_cyc, 5);
    chk("busy_start done_count", done_cnt, 1);
    chk("busy_start busy_cycles", busy_cnt, 4);
    chk("busy_start mem90", int'(mem[8'h90]), 32'h5A);
    chk("busy_start mem91", int'(mem[8'h91]), 32'hA5);
    chk("busy_start memE0_untouched", int'(mem[8'hE0]), int'(bg(8'hE0)));
    chk("busy_start checksum", int'(checksum), 32'hFF);
    $display("txn busy_start done_cyc=%0d checksum=%02h", done_cyc, checksum);

    // Reset at the edge ending cycle 4 of a 4-byte copy
    load_bg();
    load(8'h10, 8'h11); load(8'h11, 8'h22); load(8'h12, 8'h33); load(8'h13, 8'h44);
    src = 8'h10; dst = 8'hC0; len = 9'd4; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      if (done) done_cnt++;
      if (c == 4) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    chk("midrst flags", int'({busy, done, mem_r_en, mem_w_en}), 0);
    chk("midrst addr", int'(mem_addr), 0);
    chk("midrst wdata", int'(mem_wdata), 0);
    chk("midrst checksum", int'(checksum), 0);
    for (int c = 5; c <= 14; c++) begin
      if (done || busy) done_cnt++;
      tick();
    end
    chk("midrst no_done_or_busy", done_cnt, 0);
    chk("midrst memC0", int'(mem[8'hC0]), 32'h11);
    chk("midrst memC1", int'(mem[8'hC1]), 32'h22);
    chk("midrst memC2", int'(mem[8'hC2]), int'(bg(8'hC2)));
    chk("midrst memC3", int'(mem[8'hC3]), int'(bg(8'hC3)));
    $display("txn midrst checksum=%02h", checksum);

    // Back-to-back: second start in the first IDLE cycle after done
    load_bg();
    src = 8'h50; dst = 8'h60; len = 9'd1; start = 1'b1;
    tick();
    start = 1'b0;
    done_cyc = -1; done_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done) begin
        done_cnt++;
        if (c > 4 && done_cyc < 0) done_cyc = c;
      end
      if (c == 4) begin
        src = 8'h51; dst = 8'h61; len = 9'd1; start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("b2b second_done_cycle", done_cyc, 7);
    chk("b2b done_count", done_cnt, 2);
    chk("b2b mem60", int'(mem[8'h60]), int'(bg(8'h50)));
    chk("b2b mem61", int'(mem[8'h61]), int'(bg(8'h51)));
    chk("b2b checksum", int'(checksum), 32'h24);
    $display("txn b2b done_cyc=%0d checksum=%02h", done_cyc, checksum);

    chk("mon r_en_and_w_en", viol_both, 0);
    chk("mon addr_unstable", viol_addr, 0);
    chk("mon done_width", viol_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
